mem_phase_seq: RTL and testbench

MEM_PHASE_SEQ -- requirements
Module: mem_phase_seq

---
 rtl/mem_phase_seq_if.sv | 43 ++++
 rtl/mem_phase_seq.sv | 141 ++++++++++++++
 tb/tb_mem_phase_seq.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_phase_seq_if.sv
// Core/memory bundle for the phase sequencer: burst request fields in,
// per-phase memory strobes and registered burst results out.
interface mem_phase_seq_if;
  logic        req;
  logic        ready;
  logic        stall;
  logic [15:0] pc1_addr;
  logic [15:0] pc2_addr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_we;
  logic        i1re;
  logic        i2re;
  logic        dre;
  logic        gwe;
  logic [15:0] i1addr;
  logic [15:0] i2addr;
  logic [15:0] daddr;
  logic [15:0] din;
  logic        dwe;
  logic [15:0] i1data;
  logic [15:0] i2data;
  logic [15:0] ddata;
  logic [15:0] rsp_i1;
  logic [15:0] rsp_i2;
  logic [15:0] rsp_d;
  logic        rsp_valid;
  logic        wr_err;

  modport master (
    output req, stall, pc1_addr, pc2_addr, d_addr, d_wdata, d_we,
    output i1data, i2data, ddata,
    input  ready, i1re, i2re, dre, gwe, i1addr, i2addr, daddr, din, dwe,
    input  rsp_i1, rsp_i2, rsp_d, rsp_valid, wr_err
  );

  modport slave (
    input  req, stall, pc1_addr, pc2_addr, d_addr, d_wdata, d_we,
    input  i1data, i2data, ddata,
    output ready, i1re, i2re, dre, gwe, i1addr, i2addr, daddr, din, dwe,
    output rsp_i1, rsp_i2, rsp_d, rsp_valid, wr_err
  );
endinterface

// File: rtl/mem_phase_seq.sv
// Four-phase memory burst sequencer: fetch1, fetch2, data read, global write,
// with registered request fields and a one-cycle result pulse after P4.
module mem_phase_seq #(
  parameter logic [15:0] DATA_ADDR_MAX = 16'd31
) (
  input logic             idclk,
  input logic             rst_n,
  mem_phase_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        ready_c;
  logic        accept;
  logic        i1re_c;
  logic        i2re_c;
  logic        dre_c;
  logic        gwe_c;
  logic        dwe_c;

  logic [15:0] i1addr_p0;
  logic [15:0] i2addr_p0;
  logic [15:0] daddr_p0;
  logic [15:0] din_p0;
  logic        we_p0;

  logic [15:0] rsp_i1_p1;
  logic [15:0] rsp_i2_p1;
  logic [15:0] rsp_d_p1;
  logic        vld_p1;
  logic        werr_p1;

  function automatic logic addr_writable(input logic [15:0] a);
    return (a <= DATA_ADDR_MAX);
  endfunction

  assign accept = bus.req & ready_c;

  always_ff @(posedge idclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = accept ? S_P1 : S_IDLE;
      S_P1:    state_d = S_P2;
      S_P2:    state_d = S_P3;
      S_P3:    state_d = S_P4;
      S_P4:    state_d = accept ? S_P1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ready is gated by rst_n so it drops with the asynchronous reset
  always_comb begin
    i1re_c  = 1'b0;
    i2re_c  = 1'b0;
    dre_c   = 1'b0;
    gwe_c   = 1'b0;
    dwe_c   = 1'b0;
    ready_c = 1'b0;
    case (state_q)
      S_IDLE: ready_c = rst_n & ~bus.stall;
      S_P1:   i1re_c  = 1'b1;
      S_P2:   i2re_c  = 1'b1;
      S_P3: begin
        dre_c = 1'b1;
        dwe_c = we_p0 & addr_writable(daddr_p0);
      end
      S_P4: begin
        gwe_c   = 1'b1;
        dwe_c   = we_p0 & addr_writable(daddr_p0);
        ready_c = rst_n & ~bus.stall;
      end
      default: ready_c = 1'b0;
    endcase
  end

  // stage p0: request fields captured on acceptance, held for the whole burst
  always_ff @(posedge idclk or negedge rst_n) begin
    if (!rst_n) begin
      i1addr_p0 <= '0;
      i2addr_p0 <= '0;
      daddr_p0  <= '0;
      din_p0    <= '0;
      we_p0     <= 1'b0;
    end else if (accept) begin
      i1addr_p0 <= bus.pc1_addr;
      i2addr_p0 <= bus.pc2_addr;
      daddr_p0  <= bus.d_addr;
      din_p0    <= bus.d_wdata;
      we_p0     <= bus.d_we;
    end
  end

  // stage p1: memory results sampled on the edge that ends P4
  always_ff @(posedge idclk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_i1_p1 <= '0;
      rsp_i2_p1 <= '0;
      rsp_d_p1  <= '0;
      vld_p1    <= 1'b0;
      werr_p1   <= 1'b0;
    end else begin
      vld_p1  <= (state_q == S_P4);
      werr_p1 <= (state_q == S_P4) & we_p0 & ~addr_writable(daddr_p0);
      if (state_q == S_P4) begin
        rsp_i1_p1 <= bus.i1data;
        rsp_i2_p1 <= bus.i2data;
        rsp_d_p1  <= bus.ddata;
      end
    end
  end

  assign bus.ready     = ready_c;
  assign bus.i1re      = i1re_c;
  assign bus.i2re      = i2re_c;
  assign bus.dre       = dre_c;
  assign bus.gwe       = gwe_c;
  assign bus.dwe       = dwe_c;
  assign bus.i1addr    = i1addr_p0;
  assign bus.i2addr    = i2addr_p0;
  assign bus.daddr     = daddr_p0;
  assign bus.din       = din_p0;
  assign bus.rsp_i1    = rsp_i1_p1;
  assign bus.rsp_i2    = rsp_i2_p1;
  assign bus.rsp_d     = rsp_d_p1;
  assign bus.rsp_valid = vld_p1;
  assign bus.wr_err    = werr_p1;

endmodule

// File: tb/tb_mem_phase_seq.sv
// Bench for mem_phase_seq: a burst-timeline reference model checks every cycle,
// plus a vector table and directed back-to-back, stall and reset sequences.
module tb_mem_phase_seq;
  localparam logic [15:0] MAX = 16'd31;

  logic idclk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  mem_phase_seq_if bus();

  mem_phase_seq #(.DATA_ADDR_MAX(MAX)) dut (
    .idclk (idclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 idclk = ~idclk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h3C3C;
  endfunction
  function automatic logic [15:0] f1(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction
  function automatic logic [15:0] f2(input logic [15:0] a);
    return {a[7:0], a[15:8]};
  endfunction

  // memory attached to the DUT: fetch ports are pure functions of the address
  logic [15:0] dmem [0:65535];
  initial for (int i = 0; i < 65536; i++) dmem[i] = init_val(16'(i));
  always @(negedge idclk) if (bus.dwe) dmem[bus.daddr] = bus.din;
  assign bus.i1data = f1(bus.i1addr);
  assign bus.i2data = f2(bus.i2addr);
  assign bus.ddata  = dmem[bus.daddr];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // reference model: list of accepted bursts with the cycle their P1 occupies
  typedef struct {
    logic [15:0] pc1, pc2, da, wd;
    logic        we;
    int          acc;
  } burst_t;
  burst_t      bq[$];
  logic [15:0] refmem [int];
  logic [15:0] e_i1 = '0, e_i2 = '0, e_d = '0;
  logic        e_werr = 1'b0;
  int          rsp_at = -10;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return refmem.exists(int'(a)) ? refmem[int'(a)] : init_val(a);
  endfunction

  function automatic int active_idx(input int c);
    int r = -1;
    foreach (bq[i]) if (c - bq[i].acc >= 0 && c - bq[i].acc <= 3) r = i;
    return r;
  endfunction

  always @(negedge rst_n) begin
    bq.delete();
    e_i1 = '0; e_i2 = '0; e_d = '0; e_werr = 1'b0;
    rsp_at = -10;
  end

  always @(posedge idclk) begin
    int     bi;
    int     ph;
    logic   take;
    burst_t nb;
    if (rst_n) begin
      bi   = active_idx(cyc);
      ph   = (bi >= 0) ? cyc - bq[bi].acc : -1;
      take = bus.req && !bus.stall && (ph < 0 || ph == 3);
      foreach (bq[i]) begin
        int d;
        d = cyc - bq[i].acc;
        if (d == 2 && bq[i].we && bq[i].da <= MAX) refmem[int'(bq[i].da)] = bq[i].wd;
        if (d == 3) begin
          e_i1   = f1(bq[i].pc1);
          e_i2   = f2(bq[i].pc2);
          e_d    = ref_rd(bq[i].da);
          e_werr = bq[i].we && (bq[i].da > MAX);
          rsp_at = cyc + 1;
        end
      end
      if (take) begin
        nb.pc1 = bus.pc1_addr; nb.pc2 = bus.pc2_addr;
        nb.da  = bus.d_addr;   nb.wd  = bus.d_wdata;
        nb.we  = bus.d_we;     nb.acc = cyc + 1;
        bq.push_back(nb);
      end
      while (bq.size() > 0 && (cyc + 1 - bq[0].acc) > 3) void'(bq.pop_front());
    end
    cyc = cyc + 1;
  end

  always @(negedge idclk) begin
    int         bi;
    int         p;
    logic [7:0] exp;
    logic [7:0] got;
    got = {bus.i1re, bus.i2re, bus.dre, bus.gwe, bus.dwe, bus.ready, bus.rsp_valid, bus.wr_err};
    if (!rst_n) begin
      chk("reset_ctrl", got, 8'h00);
      chk("reset_data", {bus.i1addr, bus.i2addr, bus.daddr, bus.din,
                         bus.rsp_i1, bus.rsp_i2, bus.rsp_d}, '0);
    end else begin
      bi = active_idx(cyc);
      p  = (bi >= 0) ? cyc - bq[bi].acc : -1;
      exp[7] = (p == 0);
      exp[6] = (p == 1);
      exp[5] = (p == 2);
      exp[4] = (p == 3);
      exp[3] = (p == 2 || p == 3) && bq[bi].we && (bq[bi].da <= MAX);
      exp[2] = !bus.stall && (p < 0 || p == 3);
      exp[1] = (cyc == rsp_at);
      exp[0] = (cyc == rsp_at) && e_werr;
      chk("ctrl", got, exp);
      chk("rsp_hold", {bus.rsp_i1, bus.rsp_i2, bus.rsp_d}, {e_i1, e_i2, e_d});
      if (bi >= 0)
        chk("burst_fields", {bus.i1addr, bus.i2addr, bus.daddr, bus.din},
            {bq[bi].pc1, bq[bi].pc2, bq[bi].da, bq[bi].wd});
    end
  end

  task automatic tick();
    @(posedge idclk);
    #1;
  endtask

  // issues one burst from IDLE and waits (bounded) for its result pulse
  task automatic run_burst(input logic [15:0] p1, p2, da, wd, input logic we,
                           output int dwe_cnt, output logic got_v,
                           output logic [15:0] r1, rd, output logic werr);
    dwe_cnt = 0; got_v = 1'b0; r1 = '0; rd = '0; werr = 1'b0;
    bus.pc1_addr = p1; bus.pc2_addr = p2; bus.d_addr = da;
    bus.d_wdata = wd; bus.d_we = we; bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge idclk);
      if (bus.dwe) dwe_cnt++;
      if (bus.rsp_valid) begin
        got_v = 1'b1; r1 = bus.rsp_i1; rd = bus.rsp_d; werr = bus.wr_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] p1, p2, da, wd;
    logic        we;
    int          e_dwe;
    logic        e_werr;
    logic [15:0] e_d;
  } vec_t;

  initial begin
    vec_t        tbl[8];
    int          dc;
    logic        gv, we_r;
    logic [15:0] r1, rd;
    int          pulses[$];
    int          i1_cnt, v_cnt, rcnt;

    tbl[0] = '{16'h2008, 16'h2009, 16'd5,    16'h0000, 1'b0, 0, 1'b0, init_val(16'd5)};
    tbl[1] = '{16'h1000, 16'h1001, 16'd31,   16'hBEEF, 1'b1, 2, 1'b0, 16'hBEEF};
    tbl[2] = '{16'h1002, 16'h1003, 16'd31,   16'h0000, 1'b0, 0, 1'b0, 16'hBEEF};
    tbl[3] = '{16'h1004, 16'h1005, 16'd32,   16'hDEAD, 1'b1, 0, 1'b1, init_val(16'd32)};
    tbl[4] = '{16'h1006, 16'h1007, 16'd32,   16'h0000, 1'b0, 0, 1'b0, init_val(16'd32)};
    tbl[5] = '{16'h3000, 16'h3001, 16'd0,    16'h1234, 1'b1, 2, 1'b0, 16'h1234};
    tbl[6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h5555, 1'b1, 0, 1'b1, init_val(16'hFFFF)};
    tbl[7] = '{16'h0001, 16'h8000, 16'd0,    16'h0000, 1'b0, 0, 1'b0, 16'h1234};

    bus.req = 1'b0; bus.stall = 1'b0; bus.d_we = 1'b0;
    bus.pc1_addr = '0; bus.pc2_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge idclk);
    chk("ready_after_reset", bus.ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      run_burst(tbl[i].p1, tbl[i].p2, tbl[i].da, tbl[i].wd, tbl[i].we, dc, gv, r1, rd, we_r);
      chk($sformatf("tbl%0d_valid", i), gv, 1'b1);
      chk($sformatf("tbl%0d_rsp_i1", i), r1, f1(tbl[i].p1));
      chk($sformatf("tbl%0d_rsp_d", i), rd, tbl[i].e_d);
      chk($sformatf("tbl%0d_wr_err", i), we_r, tbl[i].e_werr);
      chk($sformatf("tbl%0d_dwe_cycles", i), dc, tbl[i].e_dwe);
    end

    // back-to-back: req held through three acceptances
    bus.req = 1'b1; bus.d_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.pc1_addr = 16'($urandom); bus.pc2_addr = 16'($urandom);
      bus.d_addr = 16'($urandom_range(0, 40));
      tick();
      if (i == 8) bus.req = 1'b0;
      @(negedge idclk);
      if (bus.rsp_valid) pulses.push_back(cyc);
    end
    chk("b2b_pulse_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      chk("b2b_gap1", pulses[1] - pulses[0], 4);
      chk("b2b_gap2", pulses[2] - pulses[1], 4);
    end

    // stall raised in P2 and held: burst finishes, nothing new starts
    tick();
    bus.req = 1'b1; bus.d_addr = 16'd9;
    tick();
    bus.req = 1'b0;
    tick();
    bus.stall = 1'b1; bus.req = 1'b1;
    i1_cnt = 0; v_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge idclk);
      if (bus.i1re) i1_cnt++;
      if (bus.rsp_valid) v_cnt++;
      tick();
    end
    chk("stall_rsp_count", v_cnt, 1);
    chk("stall_no_new_p1", i1_cnt, 0);
    bus.stall = 1'b0;
    @(negedge idclk);
    chk("stall_release_ready", bus.ready, 1'b1);
    tick();
    bus.req = 1'b0;
    @(negedge idclk);
    chk("stall_release_p1", bus.i1re, 1'b1);
    repeat (6) tick();

    // reset asserted during P3 of a write burst
    bus.d_addr = 16'd7; bus.d_wdata = 16'h7777; bus.d_we = 1'b1; bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("reset_mid_strobes", {bus.i1re, bus.i2re, bus.dre, bus.gwe, bus.dwe}, 5'b0);
    tick();
    tick();
    rst_n = 1'b1;
    v_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge idclk);
      if (bus.rsp_valid) v_cnt++;
    end
    chk("reset_mid_no_rsp", v_cnt, 0);
    tick();
    run_burst(16'h4000, 16'h4001, 16'd7, 16'h0000, 1'b0, dc, gv, r1, rd, we_r);
    chk("post_reset_valid", gv, 1'b1);
    chk("post_reset_rsp_d", rd, init_val(16'd7));

    // randomized traffic with occasional resets
    rcnt = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      bus.req      = ($urandom_range(0, 9) < 6);
      bus.stall    = ($urandom_range(0, 9) < 2);
      bus.pc1_addr = 16'($urandom);
      bus.pc2_addr = 16'($urandom);
      bus.d_addr   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(25, 40));
      bus.d_wdata  = 16'($urandom);
      bus.d_we     = $urandom_range(0, 1) == 1;
      if (!rst_n) begin
        if (rcnt == 0) rst_n = 1'b1;
        else rcnt--;
      end else if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        rcnt  = $urandom_range(0, 1);
      end
    end
    rst_n = 1'b1; bus.req = 1'b0; bus.stall = 1'b0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
